basket_controller: RTL and testbench
====================================

BASKET_CONTROLLER -- requirements
Module: basket_controller

Interface
REQ-001 Parameter NUM_PRODUCTS, default 12, number of valid product IDs (0..NUM_PRODUCTS-1).
REQ-002 Parameter MAX_QTY, default 15, maximum held quantity per product.
REQ-003 Parameter PRICE_STEP, default 10, unit price of product i SHALL be PRICE_STEP*(i+1).
REQ-004 CLOCK_50  in  1  sole clock; all state changes on the rising edge.
REQ-005 RESET_N  in  1  reset, synchronous, active-low.
REQ-006 Enable_Pulse  in  1  one-cycle command strobe from the state machine.
REQ-007 Remove  in  1  sampled with Enable_Pulse; 0 = add, 1 = remove.
REQ-008 Clear_Pulse  in  1  one-cycle basket clear.
REQ-009 ProductID  in  4  product ID, sampled with Enable_Pulse.
REQ-010 ProductQuantity  in  4  quantity, sampled with Enable_Pulse.
REQ-011 Rd_ID  in  4  per-product quantity read address.
REQ-012 Rd_Qty  out  4  held quantity of Rd_ID, registered, 1-cycle latency; 0 for invalid Rd_ID.
REQ-013 Busy  out  1  high while a command is in flight.
REQ-014 Done  out  1  one-cycle pulse on command completion, accepted or rejected.
REQ-015 Error  out  1  one-cycle pulse, coincident with Done, on rejected command.
REQ-016 ErrorCode  out  2  00 ok, 01 invalid ID or zero qty, 10 add overflow, 11 remove underflow.
REQ-017 TotalPrice  out  16  sum over products of qty*unit price.
REQ-018 ItemCount  out  8  sum of held quantities.
REQ-019 DistinctCount  out  4  number of products with nonzero quantity.

Function
REQ-020 FSM states SHALL be IDLE, CHECK, CALC, COMMIT; IDLE->CHECK on Enable_Pulse, then unconditional CHECK->CALC->COMMIT->IDLE.
REQ-021 ProductID, ProductQuantity, Remove SHALL be captured into internal registers on the edge that leaves IDLE.
REQ-022 Busy SHALL equal (state != IDLE).
REQ-023 Enable_Pulse while Busy SHALL be ignored, no state or output change.
REQ-024 CHECK: ID >= NUM_PRODUCTS or qty 0 -> code 01; add with held+qty > MAX_QTY -> code 10; remove with qty > held -> code 11.
REQ-025 CALC: delta = PRICE_STEP*(ID+1)*qty, computed in at least 16 bits.
REQ-026 COMMIT, accepted: held qty, TotalPrice, ItemCount, DistinctCount updated by +/- qty/delta on the COMMIT->IDLE edge.
REQ-027 DistinctCount SHALL increment on 0->nonzero and decrement on nonzero->0 transitions only.
REQ-028 COMMIT, rejected: no basket state change.
REQ-029 Done (and Error if rejected) SHALL be high in the first IDLE cycle after COMMIT, i.e. the 4th cycle after the Enable_Pulse cycle; updated totals visible in that same cycle.
REQ-030 ErrorCode SHALL update with Done and hold until the next Done.
REQ-031 Clear_Pulse SHALL zero all quantities, TotalPrice, ItemCount, DistinctCount, ErrorCode on the next edge and force IDLE, aborting any in-flight command without Done.
REQ-032 Clear_Pulse and Enable_Pulse in the same cycle: clear wins, enable discarded.
REQ-033 Arithmetic SHALL never wrap: rejection rules bound TotalPrice <= 11700 and ItemCount <= 180 at defaults.

Reset
REQ-034 RESET_N low at an edge SHALL set state IDLE, all quantities 0, TotalPrice 0, ItemCount 0, DistinctCount 0, ErrorCode 00, Busy/Done/Error 0, Rd_Qty 0.
REQ-035 Reset mid-command SHALL discard the command with no Done; reset has priority over Clear_Pulse and Enable_Pulse.

Verification
REQ-036 Reset; add ID 2 qty 3 -> Done at cycle +4, ErrorCode 00, TotalPrice 90, ItemCount 3, DistinctCount 1; Rd_ID=2 -> Rd_Qty 3.
REQ-037 Then add ID 2 qty 13 -> Done+Error, ErrorCode 10, TotalPrice 90 unchanged; then remove ID 2 qty 4 -> ErrorCode 11.
REQ-038 Then remove ID 2 qty 3 -> TotalPrice 0, ItemCount 0, DistinctCount 0; add ID 12 qty 1 or ID 0 qty 0 -> ErrorCode 01.
REQ-039 Add ID 11 qty 15, second Enable_Pulse during Busy -> single Done, TotalPrice 1800, ItemCount 15.
REQ-040 Add ID 5 qty 2, Clear_Pulse in CALC -> no Done, next cycle all totals 0, Busy 0.
REQ-041 Fill all 12 IDs to qty 15 -> TotalPrice 11700, ItemCount 180, DistinctCount 12; RESET_N low one cycle -> all zero.

Source files
------------

// File: rtl/basket_controller.sv
// Shopping-basket controller: four-stage command FSM (check, price, commit)
// over a per-product quantity table with running price/item/distinct totals.
module basket_controller #(
  parameter int unsigned NUM_PRODUCTS = 12,
  parameter int unsigned MAX_QTY      = 15,
  parameter int unsigned PRICE_STEP   = 10
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        Enable_Pulse,
  input  logic        Remove,
  input  logic        Clear_Pulse,
  input  logic [3:0]  ProductID,
  input  logic [3:0]  ProductQuantity,
  input  logic [3:0]  Rd_ID,
  output logic [3:0]  Rd_Qty,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [1:0]  ErrorCode,
  output logic [15:0] TotalPrice,
  output logic [7:0]  ItemCount,
  output logic [3:0]  DistinctCount
);

  typedef enum logic [1:0] {IDLE, CHECK, CALC, COMMIT} state_t;

  localparam logic [4:0] NUM_P = 5'(NUM_PRODUCTS);
  localparam logic [4:0] MAX_Q = 5'(MAX_QTY);

  state_t      state_q, state_d;
  logic [3:0]  id_q, id_d;
  logic [3:0]  qin_q, qin_d;
  logic        rem_q, rem_d;
  logic [1:0]  code_q, code_d;
  logic [15:0] delta_q, delta_d;
  logic [3:0]  qty_q [NUM_PRODUCTS];
  logic [3:0]  qty_d [NUM_PRODUCTS];
  logic [15:0] total_q, total_d;
  logic [7:0]  items_q, items_d;
  logic [3:0]  distinct_q, distinct_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [3:0]  rd_qty_q, rd_qty_d;
  logic [3:0]  held;

  always_comb begin
    held = '0;
    for (int unsigned i = 0; i < NUM_PRODUCTS; i++)
      if (id_q == 4'(i)) held = qty_q[i];
  end

  always_comb begin
    rd_qty_d = '0;
    for (int unsigned i = 0; i < NUM_PRODUCTS; i++)
      if (Rd_ID == 4'(i)) rd_qty_d = qty_q[i];
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    qin_d      = qin_q;
    rem_d      = rem_q;
    code_d     = code_q;
    delta_d    = delta_q;
    qty_d      = qty_q;
    total_d    = total_q;
    items_d    = items_q;
    distinct_d = distinct_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (Enable_Pulse) begin
          id_d    = ProductID;
          qin_d   = ProductQuantity;
          rem_d   = Remove;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if ({1'b0, id_q} >= NUM_P || qin_q == '0)
          code_d = 2'b01;
        else if (!rem_q && ({1'b0, held} + {1'b0, qin_q}) > MAX_Q)
          code_d = 2'b10;
        else if (rem_q && qin_q > held)
          code_d = 2'b11;
        else
          code_d = 2'b00;
        state_d = CALC;
      end
      CALC: begin
        delta_d = 16'(PRICE_STEP) * (16'(id_q) + 16'd1) * 16'(qin_q);
        state_d = COMMIT;
      end
      COMMIT: begin
        done_d     = 1'b1;
        error_d    = (code_q != 2'b00);
        err_code_d = code_q;
        if (code_q == 2'b00) begin
          for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
            if (id_q == 4'(i)) begin
              if (rem_q) begin
                qty_d[i] = qty_q[i] - qin_q;
                if (qty_q[i] == qin_q) distinct_d = distinct_q - 4'd1;
              end else begin
                qty_d[i] = qty_q[i] + qin_q;
                if (qty_q[i] == '0) distinct_d = distinct_q + 4'd1;
              end
            end
          end
          if (rem_q) begin
            total_d = total_q - delta_q;
            items_d = items_q - 8'(qin_q);
          end else begin
            total_d = total_q + delta_q;
            items_d = items_q + 8'(qin_q);
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear overrides everything above, including a same-cycle enable.
    if (Clear_Pulse) begin
      state_d    = IDLE;
      for (int unsigned i = 0; i < NUM_PRODUCTS; i++) qty_d[i] = '0;
      total_d    = '0;
      items_d    = '0;
      distinct_d = '0;
      err_code_d = '0;
      done_d     = 1'b0;
      error_d    = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      id_q       <= '0;
      qin_q      <= '0;
      rem_q      <= 1'b0;
      code_q     <= '0;
      delta_q    <= '0;
      for (int unsigned i = 0; i < NUM_PRODUCTS; i++) qty_q[i] <= '0;
      total_q    <= '0;
      items_q    <= '0;
      distinct_q <= '0;
      err_code_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rd_qty_q   <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      qin_q      <= qin_d;
      rem_q      <= rem_d;
      code_q     <= code_d;
      delta_q    <= delta_d;
      qty_q      <= qty_d;
      total_q    <= total_d;
      items_q    <= items_d;
      distinct_q <= distinct_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
      error_q    <= error_d;
      rd_qty_q   <= rd_qty_d;
    end
  end

  assign Busy          = (state_q != IDLE);
  assign Done          = done_q;
  assign Error         = error_q;
  assign ErrorCode     = err_code_q;
  assign TotalPrice    = total_q;
  assign ItemCount     = items_q;
  assign DistinctCount = distinct_q;
  assign Rd_Qty        = rd_qty_q;

endmodule

// File: tb/tb_basket_controller.sv
// Directed bench for basket_controller with hand-computed expectations.
module tb_basket_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        rem = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  pid = '0;
  logic [3:0]  pqty = '0;
  logic [3:0]  rd_id = '0;
  logic [3:0]  rd_qty;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [15:0] total;
  logic [7:0]  items;
  logic [3:0]  distinct;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  basket_controller #(.NUM_PRODUCTS(12), .MAX_QTY(15), .PRICE_STEP(10)) dut (
    .CLOCK_50        (clk),
    .RESET_N         (rst_n),
    .Enable_Pulse    (en),
    .Remove          (rem),
    .Clear_Pulse     (clr),
    .ProductID       (pid),
    .ProductQuantity (pqty),
    .Rd_ID           (rd_id),
    .Rd_Qty          (rd_qty),
    .Busy            (busy),
    .Done            (done),
    .Error           (error),
    .ErrorCode       (err_code),
    .TotalPrice      (total),
    .ItemCount       (items),
    .DistinctCount   (distinct)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_totals(input string tag, input int tp, input int ic, input int dc);
    check({tag, ".total"},    32'(total),    32'(tp));
    check({tag, ".items"},    32'(items),    32'(ic));
    check({tag, ".distinct"}, 32'(distinct), 32'(dc));
  endtask

  // Issue a command and follow it to the Done cycle (4th cycle after the pulse).
  task automatic do_cmd(input logic [3:0] id, input logic [3:0] q, input logic r,
                        input logic dup_en, input logic [1:0] exp_code);
    @(negedge clk); en = 1'b1; pid = id; pqty = q; rem = r;
    @(negedge clk); en = dup_en; pid = 4'd0; pqty = 4'd1; rem = 1'b0;
    check("busy_check", 32'(busy), 32'd1);
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    check("done_early", 32'(done), 32'd0);
    @(negedge clk);
    check("done",  32'(done),     32'd1);
    check("error", 32'(error),    32'(exp_code != 2'b00));
    check("code",  32'(err_code), 32'(exp_code));
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_code", 32'(err_code), 32'd0);
    check("rst_rdqty", 32'(rd_qty), 32'd0);
    check_totals("rst", 0, 0, 0);
    rst_n = 1'b1;

    do_cmd(4'd2, 4'd3, 1'b0, 1'b0, 2'b00);
    check_totals("add2x3", 90, 3, 1);
    rd_id = 4'd2;
    @(negedge clk);
    check("rdqty2", 32'(rd_qty), 32'd3);

    do_cmd(4'd2, 4'd13, 1'b0, 1'b0, 2'b10);
    check_totals("ovf", 90, 3, 1);
    @(negedge clk); en = 1'b1; pid = 4'd2; pqty = 4'd4; rem = 1'b1;
    @(negedge clk); en = 1'b0;
    check("code_hold", 32'(err_code), 32'd2);
    repeat (3) @(negedge clk);
    check("unf_code", 32'(err_code), 32'd3);
    check("unf_error", 32'(error), 32'd1);
    check_totals("unf", 90, 3, 1);

    do_cmd(4'd2, 4'd3, 1'b1, 1'b0, 2'b00);
    check_totals("rem2x3", 0, 0, 0);
    do_cmd(4'd12, 4'd1, 1'b0, 1'b0, 2'b01);
    do_cmd(4'd0, 4'd0, 1'b0, 1'b0, 2'b01);
    check_totals("bad", 0, 0, 0);

    do_cmd(4'd11, 4'd15, 1'b0, 1'b1, 2'b00);
    check_totals("add11x15", 1800, 15, 1);
    @(negedge clk);
    check("single_done", 32'(done), 32'd0);
    check("single_busy", 32'(busy), 32'd0);
    check_totals("after_dup", 1800, 15, 1);

    @(negedge clk); en = 1'b1; pid = 4'd5; pqty = 4'd2; rem = 1'b0;
    @(negedge clk); en = 1'b0;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_done", 32'(done), 32'd0);
    check_totals("clr", 0, 0, 0);
    repeat (3) @(negedge clk);
    check("clr_nodone", 32'(done), 32'd0);
    check_totals("clr_late", 0, 0, 0);

    @(negedge clk); en = 1'b1; clr = 1'b1; pid = 4'd1; pqty = 4'd1; rem = 1'b0;
    @(negedge clk); en = 1'b0; clr = 1'b0;
    check("clr_wins_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 12; i++) do_cmd(4'(i), 4'd15, 1'b0, 1'b0, 2'b00);
    check_totals("full", 11700, 180, 12);
    do_cmd(4'd0, 4'd1, 1'b0, 1'b0, 2'b10);
    check_totals("full_ovf", 11700, 180, 12);
    rd_id = 4'd11;
    @(negedge clk);
    check("rdqty11", 32'(rd_qty), 32'd15);
    rd_id = 4'd13;
    @(negedge clk);
    check("rdqty_inv", 32'(rd_qty), 32'd0);

    rd_id = 4'd3;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_totals("reset2", 0, 0, 0);
    check("reset2_code", 32'(err_code), 32'd0);
    check("reset2_rdqty", 32'(rd_qty), 32'd0);
    @(negedge clk);
    check("reset2_rdqty3", 32'(rd_qty), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
